// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// FSM states, ALU-op classes and ALU control values.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12,
        LOGIEX  = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IMM   = 2'b11
    } aluop_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's ALU-op class plus opcode/funct fields onto
// the 3-bit ALU control code.
module mc_aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop_t'(aluop))
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            ALUOP_IMM: begin
                // Only andi/ori reach the immediate-logic class.
                case (op)
                    OP_ANDI: alucontrol = ALU_AND;
                    OP_ORI:  alucontrol = ALU_OR;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback over a shared ALU and a single wait-stated memory port.
module mc_controller
    import mips_pkg::*;
#(
    parameter logic HAS_BNE       = 1'b1,
    parameter logic HAS_IMM_LOGIC = 1'b1,
    parameter logic HAS_MEMREADY  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       zeroext,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    aluop_t aluop;
    logic   ready;
    logic   pcwrite;
    logic   beq_st;
    logic   bne_st;

    assign ready = HAS_MEMREADY ? memready : 1'b1;
    assign state = state_q;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value of state_d regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every output and state_d gets a default before the case so no
    // path through the decode leaves a signal unassigned (no inferred latch).
    always_comb begin
        state_d    = state_q;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        beq_st     = 1'b0;
        bne_st     = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        zeroext    = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                if (ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    OP_BNE: begin
                        if (HAS_BNE) begin
                            state_d = BNEEX;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = FETCH;
                        end
                    end
                    OP_ANDI, OP_ORI: begin
                        if (HAS_IMM_LOGIC) begin
                            state_d = LOGIEX;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = FETCH;
                        end
                    end
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                if (ready) state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                // The write strobe is held across the wait so the memory sees
                // a stable request until it acknowledges.
                iord     = 1'b1;
                memwrite = 1'b1;
                if (ready) state_d = FETCH;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                beq_st  = 1'b1;
                state_d = FETCH;
            end
            BNEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                bne_st  = 1'b1;
                state_d = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = IMMWB;
            end
            LOGIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_IMM;
                zeroext = 1'b1;
                state_d = IMMWB;
            end
            IMMWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign pcen = pcwrite | (beq_st & zero) | (bne_st & ~zero);

    mc_aludec u_aludec (
        .aluop      (aluop),
        .op         (op),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
